// File: rtl/wolf_rx_pkg.sv
// Shared RX IQ types for the DDC -> STM32 sample path.
// RX_IQ_FIFO_RX2_EN selects whether RX2 I/Q is carried (96-bit entry) or dropped (48-bit entry).
package wolf_rx_pkg;

  localparam int IQ_SAMPLE_W           = 24;
  localparam int DEFAULT_RX_FIFO_DEPTH = 64;

  typedef logic signed [IQ_SAMPLE_W-1:0] iq_sample_t;

  typedef struct packed {
    iq_sample_t rx1_i;
    iq_sample_t rx1_q;
    iq_sample_t rx2_i;
    iq_sample_t rx2_q;
  } rx_iq_set_t;

`ifdef RX_IQ_FIFO_RX2_EN
  localparam int RX_IQ_ENTRY_W = 4 * IQ_SAMPLE_W;
`else
  localparam int RX_IQ_ENTRY_W = 2 * IQ_SAMPLE_W;
`endif

  // Expand a stored FIFO entry back into a full set; absent channels read as zero.
  function automatic rx_iq_set_t unpack_entry(input logic [RX_IQ_ENTRY_W-1:0] e);
    rx_iq_set_t s;
`ifdef RX_IQ_FIFO_RX2_EN
    s = e;
`else
    s.rx1_i = e[2*IQ_SAMPLE_W-1:IQ_SAMPLE_W];
    s.rx1_q = e[IQ_SAMPLE_W-1:0];
    s.rx2_i = '0;
    s.rx2_q = '0;
`endif
    return s;
  endfunction

endpackage

// File: rtl/rx_iq_fifo_mem.sv
// Simple dual-port sample-set storage: synchronous write, registered read-first output.
// Entry width follows RX_IQ_FIFO_RX2_EN through wolf_rx_pkg::RX_IQ_ENTRY_W.
module rx_iq_fifo_mem
  import wolf_rx_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_RX_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WIDTH  = RX_IQ_ENTRY_W
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first: a full-FIFO write+pop hits the same address and must return the old set.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_iq_fifo.sv
// RX IQ sample-set FIFO between the DDC and the STM32 bus interface, with sticky overrun.
// Define RX_IQ_FIFO_RX2_EN to store RX2 I/Q; otherwise RX2 outputs are tied to zero.
module rx_iq_fifo
  import wolf_rx_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_RX_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk_in,
  input  logic                   reset_n,
  input  logic                   iq_valid,
  input  logic signed [23:0]     ddc_rx1_i,
  input  logic signed [23:0]     ddc_rx1_q,
  input  logic signed [23:0]     ddc_rx2_i,
  input  logic signed [23:0]     ddc_rx2_q,
  input  logic                   IQ_RX_READ_REQ,
  input  logic                   IQ_RX_READ_CLK,
  input  logic                   overrun_clear,
  output logic signed [23:0]     RX1_I,
  output logic signed [23:0]     RX1_Q,
  output logic signed [23:0]     RX2_I,
  output logic signed [23:0]     RX2_Q,
  output logic                   in_empty,
  output logic                   iq_overrun,
  output logic [ADDR_W:0]        fill_level
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic                     read_clk_d;
  logic                     pop_req_p0, do_pop_p0, do_wr_p0, ovr_set_p0, full_p0;
  logic [ADDR_W-1:0]        wr_ptr, rd_ptr;
  logic [ADDR_W:0]          count, count_nxt;
  logic [RX_IQ_ENTRY_W-1:0] wr_entry_p0, rd_entry_p1;
  rx_iq_set_t               rd_set_p1;

`ifdef RX_IQ_FIFO_RX2_EN
  assign wr_entry_p0 = {ddc_rx1_i, ddc_rx1_q, ddc_rx2_i, ddc_rx2_q};
`else
  logic unused_rx2;
  assign unused_rx2  = ^{ddc_rx2_i, ddc_rx2_q};
  assign wr_entry_p0 = {ddc_rx1_i, ddc_rx1_q};
`endif

  // Stage p0: decode this cycle's pop/write against the registered occupancy.
  always_comb begin
    pop_req_p0 = IQ_RX_READ_REQ & IQ_RX_READ_CLK & ~read_clk_d;
    full_p0    = (count == FULL_CNT);
    do_pop_p0  = pop_req_p0 && (count != '0);
    do_wr_p0   = iq_valid && (!full_p0 || do_pop_p0);
    ovr_set_p0 = iq_valid && full_p0 && !do_pop_p0;
    count_nxt  = count;
    if (do_wr_p0 && !do_pop_p0)      count_nxt = count + CNT_ONE;
    else if (do_pop_p0 && !do_wr_p0) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      read_clk_d <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_empty   <= 1'b1;
      iq_overrun <= 1'b0;
    end else begin
      read_clk_d <= IQ_RX_READ_CLK;
      if (do_wr_p0)  wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop_p0) rd_ptr <= rd_ptr + PTR_ONE;
      count    <= count_nxt;
      in_empty <= (count_nxt == '0);
      // A new overrun in the same cycle as a clear keeps the flag set.
      if (ovr_set_p0)         iq_overrun <= 1'b1;
      else if (overrun_clear) iq_overrun <= 1'b0;
    end
  end

  assign fill_level = count;

  rx_iq_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (RX_IQ_ENTRY_W)
  ) u_mem (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .wr_en   (do_wr_p0),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry_p0),
    .rd_en   (do_pop_p0),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry_p1)
  );

  // Stage p1: registered head-of-FIFO set, held until the next accepted pop.
  assign rd_set_p1 = unpack_entry(rd_entry_p1);
  assign RX1_I     = rd_set_p1.rx1_i;
  assign RX1_Q     = rd_set_p1.rx1_q;
  assign RX2_I     = rd_set_p1.rx2_i;
  assign RX2_Q     = rd_set_p1.rx2_q;

endmodule

// File: tb/tb_rx_iq_fifo.sv
// Self-checking bench for rx_iq_fifo: directed scenarios plus random traffic against a queue model.
module tb_rx_iq_fifo;
  import wolf_rx_pkg::*;

  localparam int DEPTH = 64;

  logic               clk_in = 1'b0;
  logic               reset_n;
  logic               iq_valid, req, rclk, clr;
  rx_iq_set_t         din;
  logic signed [23:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
  logic               in_empty, iq_overrun;
  logic [6:0]         fill_level;

  rx_iq_fifo #(.DEPTH(DEPTH)) dut (
    .clk_in         (clk_in),
    .reset_n        (reset_n),
    .iq_valid       (iq_valid),
    .ddc_rx1_i      (din.rx1_i),
    .ddc_rx1_q      (din.rx1_q),
    .ddc_rx2_i      (din.rx2_i),
    .ddc_rx2_q      (din.rx2_q),
    .IQ_RX_READ_REQ (req),
    .IQ_RX_READ_CLK (rclk),
    .overrun_clear  (clr),
    .RX1_I          (RX1_I),
    .RX1_Q          (RX1_Q),
    .RX2_I          (RX2_I),
    .RX2_Q          (RX2_Q),
    .in_empty       (in_empty),
    .iq_overrun     (iq_overrun),
    .fill_level     (fill_level)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: a queue of sets, the last popped set, the sticky flag, last READ_CLK level.
  rx_iq_set_t mq[$];
  rx_iq_set_t m_out;
  bit         m_ovr;
  bit         m_prev;
  int         nvec = 0;
  int         nerr = 0;

  function automatic logic [95:0] set_bus(input rx_iq_set_t s);
`ifdef RX_IQ_FIFO_RX2_EN
    return {s.rx1_i, s.rx1_q, s.rx2_i, s.rx2_q};
`else
    return {s.rx1_i, s.rx1_q, 48'd0};
`endif
  endfunction

  function automatic logic [8:0] exp_status();
    return {mq.size() == 0, m_ovr, 7'(mq.size())};
  endfunction

  function automatic rx_iq_set_t rand_set();
    rx_iq_set_t s;
    s.rx1_i = 24'($urandom);
    s.rx1_q = 24'($urandom);
    s.rx2_i = 24'($urandom);
    s.rx2_q = 24'($urandom);
    return s;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_out  = '0;
    m_ovr  = 1'b0;
    m_prev = 1'b0;
  endtask

  // One clk_in edge: update the model from the inputs the DUT sampled, then drop one-cycle pulses.
  task automatic cyc();
    bit pop;
    @(posedge clk_in);
    pop = req && rclk && !m_prev;
    if (pop && mq.size() > 0) m_out = mq.pop_front();
    if (clr) m_ovr = 1'b0;
    if (iq_valid) begin
      if (mq.size() < DEPTH) mq.push_back(din);
      else                   m_ovr = 1'b1;
    end
    m_prev = rclk;
    #1;
    iq_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic wr_one();
    din      = rand_set();
    iq_valid = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    repeat (5) wr_one();
    nvec++;
    if (fill_level !== 7'd5) begin
      nerr++; $display("FAIL reset_pre fill_level got %0d want 5", fill_level);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    nvec++;
    if ({in_empty, iq_overrun, fill_level} !== {1'b1, 1'b0, 7'd0}) begin
      nerr++; $display("FAIL reset_status got %b/%b/%0d want 1/0/0", in_empty, iq_overrun, fill_level);
    end
    nvec++;
    if ({RX1_I, RX1_Q, RX2_I, RX2_Q} !== 96'd0) begin
      nerr++; $display("FAIL reset_data got %h want 0", {RX1_I, RX1_Q, RX2_I, RX2_Q});
    end
    @(posedge clk_in);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_pass_through();
    rx_iq_set_t s;
    s.rx1_i = 24'h123456;
    s.rx1_q = 24'hFEDCBA;
    s.rx2_i = 24'sd1;
    s.rx2_q = -24'sd1;
    din = s; iq_valid = 1'b1;
    cyc();
    nvec++;
    if (in_empty !== 1'b0 || fill_level !== 7'd1) begin
      nerr++; $display("FAIL pass_write got empty=%b fill=%0d want empty=0 fill=1", in_empty, fill_level);
    end
    req = 1'b1; rclk = 1'b1;
    cyc();
    nvec++;
`ifdef RX_IQ_FIFO_RX2_EN
    if ({RX1_I, RX1_Q, RX2_I, RX2_Q} !== 96'h123456_FEDCBA_000001_FFFFFF) begin
`else
    if ({RX1_I, RX1_Q, RX2_I, RX2_Q} !== 96'h123456_FEDCBA_000000_000000) begin
`endif
      nerr++; $display("FAIL pass_data got %h", {RX1_I, RX1_Q, RX2_I, RX2_Q});
    end
    nvec++;
    if (in_empty !== 1'b1) begin
      nerr++; $display("FAIL pass_empty got %b want 1", in_empty);
    end
    rclk = 1'b0; req = 1'b0;
    cyc();
  endtask

  task automatic test_fill_overrun();
    rx_iq_set_t hist[DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      hist[i] = rand_set();
      din = hist[i]; iq_valid = 1'b1;
      cyc();
    end
    nvec++;
    if (fill_level !== 7'd64 || iq_overrun !== 1'b0) begin
      nerr++; $display("FAIL fill_full got fill=%0d ovr=%b want 64/0", fill_level, iq_overrun);
    end
    wr_one();
    nvec++;
    if (fill_level !== 7'd64 || iq_overrun !== 1'b1) begin
      nerr++; $display("FAIL fill_overrun got fill=%0d ovr=%b want 64/1", fill_level, iq_overrun);
    end
    req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rclk = 1'b1; cyc();
      nvec++;
      if ({RX1_I, RX1_Q, RX2_I, RX2_Q} !== set_bus(hist[i])) begin
        nerr++; $display("FAIL fill_pop[%0d] got %h want %h", i, {RX1_I, RX1_Q, RX2_I, RX2_Q}, set_bus(hist[i]));
      end
      rclk = 1'b0; cyc();
    end
    req = 1'b0;
    nvec++;
    if (in_empty !== 1'b1 || fill_level !== 7'd0) begin
      nerr++; $display("FAIL fill_drain got empty=%b fill=%0d want 1/0", in_empty, fill_level);
    end
    clr = 1'b1; cyc();
    nvec++;
    if (iq_overrun !== 1'b0) begin
      nerr++; $display("FAIL fill_clear got %b want 0", iq_overrun);
    end
  endtask

  task automatic test_edge_detect();
    repeat (3) wr_one();
    req = 1'b1; rclk = 1'b1;
    repeat (5) cyc();
    nvec++;
    if (fill_level !== 7'd2) begin
      nerr++; $display("FAIL edge_hold fill got %0d want 2", fill_level);
    end
    rclk = 1'b0; cyc();
    req = 1'b0; rclk = 1'b1; cyc();
    nvec++;
    if (fill_level !== 7'd2 || {RX1_I, RX1_Q, RX2_I, RX2_Q} !== set_bus(m_out)) begin
      nerr++; $display("FAIL edge_noreq fill got %0d want 2", fill_level);
    end
    rclk = 1'b0; cyc();
  endtask

  task automatic test_simultaneous();
    while (mq.size() < DEPTH) wr_one();
    din = rand_set(); iq_valid = 1'b1; req = 1'b1; rclk = 1'b1;
    cyc();
    nvec++;
    if (iq_overrun !== 1'b0 || fill_level !== 7'd64) begin
      nerr++; $display("FAIL simul_full got ovr=%b fill=%0d want 0/64", iq_overrun, fill_level);
    end
    nvec++;
    if ({RX1_I, RX1_Q, RX2_I, RX2_Q} !== set_bus(m_out)) begin
      nerr++; $display("FAIL simul_full_data got %h want %h", {RX1_I, RX1_Q, RX2_I, RX2_Q}, set_bus(m_out));
    end
    rclk = 1'b0; cyc();
    repeat (DEPTH) begin
      rclk = 1'b1; cyc();
      rclk = 1'b0; cyc();
    end
    nvec++;
    if (fill_level !== 7'd0 || in_empty !== 1'b1) begin
      nerr++; $display("FAIL simul_drain got fill=%0d empty=%b want 0/1", fill_level, in_empty);
    end
    din = rand_set(); iq_valid = 1'b1; rclk = 1'b1;
    cyc();
    nvec++;
    if (fill_level !== 7'd1 || {RX1_I, RX1_Q, RX2_I, RX2_Q} !== set_bus(m_out)) begin
      nerr++; $display("FAIL simul_empty got fill=%0d data=%h want 1/%h", fill_level, {RX1_I, RX1_Q, RX2_I, RX2_Q}, set_bus(m_out));
    end
    rclk = 1'b0; req = 1'b0; cyc();
  endtask

  task automatic test_clear_race();
    while (mq.size() < DEPTH) wr_one();
    din = rand_set(); iq_valid = 1'b1; clr = 1'b1;
    cyc();
    nvec++;
    if (iq_overrun !== 1'b1) begin
      nerr++; $display("FAIL clear_race got %b want 1", iq_overrun);
    end
    clr = 1'b1; cyc();
    nvec++;
    if (iq_overrun !== 1'b0 || fill_level !== 7'd64) begin
      nerr++; $display("FAIL clear_alone got ovr=%b fill=%0d want 0/64", iq_overrun, fill_level);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      din      = rand_set();
      iq_valid = ($urandom_range(0, 99) < 55);
      req      = ($urandom_range(0, 99) < 85);
      rclk     = $urandom_range(0, 1) != 0;
      clr      = ($urandom_range(0, 99) < 4);
      cyc();
      nvec++;
      if ({in_empty, iq_overrun, fill_level} !== exp_status() ||
          {RX1_I, RX1_Q, RX2_I, RX2_Q} !== set_bus(m_out)) begin
        nerr++;
        $display("FAIL random[%0d] got st=%b data=%h want st=%b data=%h", i,
                 {in_empty, iq_overrun, fill_level}, {RX1_I, RX1_Q, RX2_I, RX2_Q},
                 exp_status(), set_bus(m_out));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; iq_valid = 1'b0; req = 1'b0; rclk = 1'b0; clr = 1'b0; din = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 reset_n = 1'b1;
    test_reset();
    test_pass_through();
    test_fill_overrun();
    test_edge_detect();
    test_simultaneous();
    test_clear_race();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rx_iq_fifo.md
Name: rx_iq_fifo

Overview:
- Buffers decimated RX IQ sample sets between the DDC output and the STM32 bus interface. All logic runs on clk_in.
- Each write stores one set {RX1_I, RX1_Q, RX2_I, RX2_Q} of 24-bit signed samples.
- The interface pops one set per rising edge of IQ_RX_READ_CLK while IQ_RX_READ_REQ is high. It sees presented samples on RX1_I/RX1_Q/RX2_I/RX2_Q and the empty flag on in_empty.
- The block reports a sticky overrun flag, which the bus interface returns in its status byte.

Parameters:
- DEPTH, 64, number of sample sets stored; must be a power of 2, minimum 4.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk_in  in  1  system clock, shared with the STM32 interface.
- reset_n  in  1  asynchronous active-low reset.
- iq_valid  in  1  one-cycle strobe: DDC sample set valid this cycle.
- ddc_rx1_i  in  24  signed RX1 I from DDC.
- ddc_rx1_q  in  24  signed RX1 Q from DDC.
- ddc_rx2_i  in  24  signed RX2 I from DDC.
- ddc_rx2_q  in  24  signed RX2 Q from DDC.
- IQ_RX_READ_REQ  in  1  read enable from the interface.
- IQ_RX_READ_CLK  in  1  pop strobe from the interface; the rising edge is sampled on clk_in.
- overrun_clear  in  1  one-cycle pulse that clears iq_overrun.
- RX1_I  out  24  signed head-of-FIFO RX1 I, registered.
- RX1_Q  out  24  signed head-of-FIFO RX1 Q, registered.
- RX2_I  out  24  signed head-of-FIFO RX2 I, registered.
- RX2_Q  out  24  signed head-of-FIFO RX2 Q, registered.
- in_empty  out  1  FIFO holds zero sets, registered.
- iq_overrun  out  1  sticky flag: a set was dropped because the FIFO was full.
- fill_level  out  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset values (asynchronous): wr_ptr=0, rd_ptr=0, count=0, all RX outputs 0, in_empty=1, iq_overrun=0, fill_level=0, read_clk_d=0.
- Pop detect: pop_req = IQ_RX_READ_REQ & IQ_RX_READ_CLK & ~read_clk_d. read_clk_d is IQ_RX_READ_CLK delayed one clk_in cycle. A high level on IQ_RX_READ_CLK pops at most once.
- Write: on iq_valid with count<DEPTH (or count==DEPTH with a pop in the same cycle), store the set at wr_ptr. wr_ptr increments and wraps DEPTH-1 -> 0 by natural ADDR_W overflow.
- Full write: on iq_valid with count==DEPTH and no pop, the set is dropped, pointers are unchanged, and iq_overrun is set.
- Pop, non-empty: the set at rd_ptr is loaded into the RX outputs at the next clk_in edge (1-cycle latency from the pop_req cycle), rd_ptr increments and wraps, count decrements.
- Pop, empty: ignored. RX outputs hold their last value, and count and pointers are unchanged.
- No write-to-read bypass. A write into an empty FIFO lowers in_empty one cycle later, and a pop in that same cycle is ignored.
- Simultaneous write and pop, non-empty: both are performed and count is unchanged.
- Status timing: in_empty and fill_level reflect the post-update count, registered in the same edge as the pointer update.
- Clear vs set: when overrun_clear and a new overrun occur in the same cycle, set wins.
- Storage: a register array or inferred RAM with a registered read. The RX output timing above is mandatory either way.

Optional Feature:
- RX_IQ_FIFO_RX2_EN defined: RX2 I/Q is stored, and the entry width is 96 bits.
- Undefined: the entry width is 48 bits, ddc_rx2_* are ignored, RX2_I/RX2_Q are tied to 0, and all other behaviour is identical.

Decomposition:
- Shared package wolf_rx_pkg:
  - IQ_SAMPLE_W=24
  - typedef iq_sample_t (signed 24-bit)
  - typedef rx_iq_set_t (struct of RX1/RX2 I/Q)
  - DEFAULT_RX_FIFO_DEPTH=64
- One sub-module, rx_iq_fifo_mem: simple dual-port storage, DEPTH x entry width, synchronous write, registered read. Pointer, count and flag logic stay in rx_iq_fifo.

Test Plan:
- Reset: assert reset_n=0 mid-operation with count=5 -> immediately in_empty=1, fill_level=0, RX outputs 0, iq_overrun=0.
- Single pass-through: write set (RX1_I=24'h123456, RX1_Q=24'hFEDCBA, RX2_I=1, RX2_Q=-1), then one READ_CLK rising edge with REQ=1 -> outputs equal the set one cycle after the edge, and in_empty returns to 1.
- Fill and overrun: 64 writes, no pops -> fill_level=64. A 65th write -> iq_overrun=1 and fill_level stays 64. 64 pops -> the values from writes 1..64 come out in order across the wrap.
- Edge detect: hold IQ_RX_READ_CLK high for 5 cycles with 3 entries -> exactly one pop, fill_level=2. Pop with REQ=0 -> no pop.
- Simultaneous: at count=64, write and pop in the same cycle -> no overrun, count stays 64. At count=0, write and pop in the same cycle -> pop ignored and count becomes 1.
- Clear race: overrun_clear pulsed in the same cycle as a full-FIFO write -> iq_overrun stays 1. Clear pulsed alone next cycle -> iq_overrun=0.
